// File: rtl/systolic_host_link_pkg.sv
// Shared types and helpers for the host link: frame layout, beat constants and
// the per-phase beat selector used by the serialiser.
package systolic_link_pkg;

  localparam int         BEATS      = 4;
  localparam logic [1:0] PHASE_LAST = 2'd3;

  typedef logic [$clog2(BEATS)-1:0] phase_t;

  typedef struct packed {
    logic [15:0] col;
    logic [15:0] row;
    logic [3:0]  col_ctrl;
    logic [3:0]  row_ctrl;
  } frame_t;

  // Beat p carries data nibble [15-4p:12-4p] and control bit [3-p]; the
  // returned bits are {col nibble, row nibble, col ctrl bit, row ctrl bit}.
  function automatic logic [9:0] nibble_sel(frame_t f, phase_t phase);
    logic [9:0] b;
    case (phase)
      2'd0:    b = {f.col[15:12], f.row[15:12], f.col_ctrl[3], f.row_ctrl[3]};
      2'd1:    b = {f.col[11:8],  f.row[11:8],  f.col_ctrl[2], f.row_ctrl[2]};
      2'd2:    b = {f.col[7:4],   f.row[7:4],   f.col_ctrl[1], f.row_ctrl[1]};
      default: b = {f.col[3:0],   f.row[3:0],   f.col_ctrl[0], f.row_ctrl[0]};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/systolic_host_link_if.sv
// Host-side frame stream: valid/ready ingress of whole frames and a
// ready-less, single-cycle egress pulse of reassembled frames.
interface systolic_host_link_if;
  // Ingress: a frame moves on any clk edge where s_valid && s_ready; s_valid
  // and the frame fields must hold steady until that edge. Egress: m_valid is
  // a one-cycle pulse with no back-pressure, the consumer must take it.
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_col;
  logic [15:0] s_row;
  logic [3:0]  s_col_ctrl;
  logic [3:0]  s_row_ctrl;
  logic        m_valid;
  logic [15:0] m_col;
  logic [15:0] m_row;
  logic [3:0]  m_col_ctrl;
  logic [3:0]  m_row_ctrl;

  modport master (
    output s_valid, s_col, s_row, s_col_ctrl, s_row_ctrl,
    input  s_ready, m_valid, m_col, m_row, m_col_ctrl, m_row_ctrl
  );

  modport slave (
    input  s_valid, s_col, s_row, s_col_ctrl, s_row_ctrl,
    output s_ready, m_valid, m_col, m_row, m_col_ctrl, m_row_ctrl
  );
endinterface

// File: rtl/systolic_host_link_fifo.sv
// Synchronous frame FIFO; the caller only pushes when not full and only pops
// when not empty.
module link_fifo
  import systolic_link_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  frame_t wdata,
  input  logic   pop,
  output frame_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  frame_t          mem_q [DEPTH];
  frame_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q,  count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/systolic_host_link.sv
// Host link for one systolic tile: buffers host frames, serialises them into
// 4-beat nibble frames locked to the tile's beat counter, and reassembles echoes.
module systolic_host_link
  import systolic_link_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  systolic_host_link_if.slave         host,
  output logic [7:0]                  tile_ui_in,
  output logic [1:0]                  tile_uio_in,
  output logic                        tile_rst_n,
  input  logic [7:0]                  tile_uo_out,
  input  logic [1:0]                  tile_uio_out,
  output logic [1:0]                  phase
);

  phase_t     phase_q, phase_d;
  frame_t     tx_q, tx_d;
  frame_t     rx_q, rx_d;
  frame_t     m_q, m_d;
  logic       m_valid_q, m_valid_d;
  frame_t     fifo_wdata, fifo_rdata;
  logic       fifo_full, fifo_empty;
  logic       push, pop;
  logic [9:0] beat;

  assign fifo_wdata = '{col: host.s_col, row: host.s_row,
                        col_ctrl: host.s_col_ctrl, row_ctrl: host.s_row_ctrl};
  assign host.s_ready = ~fifo_full & ~rst;
  assign push = host.s_valid & host.s_ready;
  // Frames only leave on a frame boundary; a push on that same edge is not
  // yet visible, so there is no bypass into the shift register.
  assign pop  = (phase_q == PHASE_LAST) & ~fifo_empty;

  link_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    phase_d   = phase_q + phase_t'(1);
    tx_d      = tx_q;
    rx_d      = rx_q;
    m_d       = m_q;
    m_valid_d = 1'b0;
    for (int p = 0; p < BEATS; p++) begin
      if (phase_q == phase_t'(p)) begin
        rx_d.col[4*(BEATS-1-p) +: 4]  = tile_uo_out[7:4];
        rx_d.row[4*(BEATS-1-p) +: 4]  = tile_uo_out[3:0];
        rx_d.col_ctrl[BEATS-1-p]      = tile_uio_out[1];
        rx_d.row_ctrl[BEATS-1-p]      = tile_uio_out[0];
      end
    end
    // An empty FIFO sends an all-zero frame, which the tile treats as a no-op.
    if (phase_q == PHASE_LAST) begin
      tx_d      = pop ? fifo_rdata : '0;
      m_d       = rx_d;
      m_valid_d = (rx_d.col_ctrl | rx_d.row_ctrl) != 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      m_q       <= '0;
      m_valid_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      m_q       <= m_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign beat        = nibble_sel(tx_q, phase_q);
  assign tile_ui_in  = rst ? 8'd0 : beat[9:2];
  assign tile_uio_in = rst ? 2'd0 : beat[1:0];
  assign tile_rst_n  = ~rst;
  assign phase       = phase_q;

  assign host.m_valid    = m_valid_q;
  assign host.m_col      = m_q.col;
  assign host.m_row      = m_q.row;
  assign host.m_col_ctrl = m_q.col_ctrl;
  assign host.m_row_ctrl = m_q.row_ctrl;

endmodule

// File: tb/tb_systolic_host_link.sv
// Directed bench for systolic_host_link with a behavioural tile that echoes
// each frame one frame later (read-then-load of an accumulator on col_ctrl[3]).
module tb_systolic_host_link;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tile_ui_in, tile_uo_out;
  logic [1:0] tile_uio_in, tile_uio_out, phase;
  logic       tile_rst_n;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [1:0] mph;

  systolic_host_link_if bus ();

  systolic_host_link #(.DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .host         (bus.slave),
    .tile_ui_in   (tile_ui_in),
    .tile_uio_in  (tile_uio_in),
    .tile_rst_n   (tile_rst_n),
    .tile_uo_out  (tile_uo_out),
    .tile_uio_out (tile_uio_out),
    .phase        (phase)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mph <= rst ? 2'd0 : mph + 2'd1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 want finish");
    $fatal(1);
  end

  // ---------------- tile model ----------------
  logic [1:0]  tcnt;
  logic [15:0] cap_col, cap_row;
  logic [3:0]  cap_cc, cap_rc;
  logic [39:0] echo;
  logic [31:0] acc;
  logic [39:0] tile_seen[$];
  int          tile_stamp[$];

  always @(posedge clk) begin : tile_model
    logic [39:0] got;
    if (!tile_rst_n) begin
      tcnt <= 2'd0; cap_col <= '0; cap_row <= '0; cap_cc <= '0; cap_rc <= '0;
      echo <= '0; acc <= '0;
    end else begin
      tcnt    <= tcnt + 2'd1;
      cap_col <= {cap_col[11:0], tile_ui_in[7:4]};
      cap_row <= {cap_row[11:0], tile_ui_in[3:0]};
      cap_cc  <= {cap_cc[2:0], tile_uio_in[1]};
      cap_rc  <= {cap_rc[2:0], tile_uio_in[0]};
      if (tcnt == 2'd3) begin
        got = {cap_col[11:0], tile_ui_in[7:4], cap_row[11:0], tile_ui_in[3:0],
               cap_cc[2:0], tile_uio_in[1], cap_rc[2:0], tile_uio_in[0]};
        if (got != 40'd0) begin
          tile_seen.push_back(got);
          tile_stamp.push_back(cyc + 1);
        end
        if (got[7]) begin
          echo <= {acc, got[7:0]};
          acc  <= got[39:8];
        end else begin
          echo <= got;
        end
      end
    end
  end

  always_comb begin
    tile_uo_out  = {echo[39 - 4*tcnt -: 4], echo[23 - 4*tcnt -: 4]};
    tile_uio_out = {echo[7 - tcnt], echo[3 - tcnt]};
  end

  // ---------------- egress monitor / scoreboard ----------------
  logic [39:0] m_seen[$];
  int          m_stamp[$];
  logic [39:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.m_valid === 1'b1) begin
      m_seen.push_back({bus.m_col, bus.m_row, bus.m_col_ctrl, bus.m_row_ctrl});
      m_stamp.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_phase(input logic [1:0] p);
    for (int k = 0; k < 4 && mph != p; k++) step(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.s_valid = 1'b0;
    step(2);
    tile_seen.delete(); tile_stamp.delete();
    m_seen.delete(); m_stamp.delete(); exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic push(input logic [15:0] c, input logic [15:0] r,
                      input logic [3:0] cc, input logic [3:0] rc, output int at);
    logic rdy;
    bit   done;
    done = 1'b0;
    at   = -1;
    bus.s_valid = 1'b1; bus.s_col = c; bus.s_row = r;
    bus.s_col_ctrl = cc; bus.s_row_ctrl = rc;
    for (int k = 0; k < 16 && !done; k++) begin
      rdy = bus.s_ready;
      step(1);
      if (rdy) begin
        done = 1'b1;
        at   = cyc;
      end
    end
    bus.s_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL push_accept: got s_ready=0 for 16 cycles want 1");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.s_valid = 1'b0;
    step(3);
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase: got %0d want 0", phase); end
    checks++; if ({tile_ui_in, tile_uio_in} !== 10'd0) begin errors++; $display("FAIL reset_tile_in: got %h want 0", {tile_ui_in, tile_uio_in}); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
    checks++; if ({bus.m_col, bus.m_row, bus.m_col_ctrl, bus.m_row_ctrl} !== 40'd0) begin
      errors++; $display("FAIL reset_m_fields: got %h want 0", {bus.m_col, bus.m_row, bus.m_col_ctrl, bus.m_row_ctrl}); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", bus.s_ready); end
    checks++; if (tile_rst_n !== 1'b0) begin errors++; $display("FAIL reset_tile_rst_n: got %b want 0", tile_rst_n); end
    rst = 1'b0;
    #1;
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL release_s_ready: got %b want 1", bus.s_ready); end
    checks++; if (tile_rst_n !== 1'b1) begin errors++; $display("FAIL release_tile_rst_n: got %b want 1", tile_rst_n); end
    step(1);
    checks++; if (phase !== 2'd1) begin errors++; $display("FAIL release_phase: got %0d want 1", phase); end
  endtask

  task automatic test_passthrough();
    logic [7:0] ui_e  [4];
    logic [1:0] uio_e [4];
    int p;
    ui_e  = '{8'h1A, 8'h2B, 8'h3C, 8'h4D};
    uio_e = '{2'b00, 2'b00, 2'b00, 2'b11};
    do_reset();
    wait_phase(2);
    push(16'h1234, 16'hABCD, 4'b0001, 4'b0001, p);
    step(1);
    for (int b = 0; b < 4; b++) begin
      checks++; if (phase !== 2'(b)) begin errors++; $display("FAIL pass_phase%0d: got %0d want %0d", b, phase, b); end
      checks++; if (tile_ui_in !== ui_e[b]) begin errors++; $display("FAIL pass_ui%0d: got %h want %h", b, tile_ui_in, ui_e[b]); end
      checks++; if (tile_uio_in !== uio_e[b]) begin errors++; $display("FAIL pass_uio%0d: got %b want %b", b, tile_uio_in, uio_e[b]); end
      step(1);
    end
    step(8);
    checks++; if (m_seen.size() !== 1) begin errors++; $display("FAIL pass_m_count: got %0d want 1", m_seen.size()); end
    if (m_seen.size() > 0) begin
      checks++; if (m_seen[0] !== 40'h1234_ABCD_11) begin errors++; $display("FAIL pass_m_frame: got %h want 1234abcd11", m_seen[0]); end
      checks++; if (m_stamp[0] !== p + 9) begin errors++; $display("FAIL pass_m_latency: got edge %0d want %0d", m_stamp[0], p + 9); end
    end
  endtask

  task automatic test_accumulator();
    int p1, p2;
    do_reset();
    wait_phase(1);
    push(16'h0102, 16'h0304, 4'b1000, 4'b0100, p1);
    push(16'hFFFF, 16'hFFFF, 4'b1000, 4'b0100, p2);
    step(20);
    exp_q.push_back(40'h0000_0000_84);
    exp_q.push_back(40'h0102_0304_84);
    checks++; if (m_seen.size() !== exp_q.size()) begin errors++; $display("FAIL acc_m_count: got %0d want %0d", m_seen.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < m_seen.size(); i++) begin
      checks++; if (m_seen[i] !== exp_q[i]) begin errors++; $display("FAIL acc_m_frame%0d: got %h want %h", i, m_seen[i], exp_q[i]); end
      checks++; if (m_stamp[i] !== p1 + 10 + 4*i) begin errors++; $display("FAIL acc_m_time%0d: got edge %0d want %0d", i, m_stamp[i], p1 + 10 + 4*i); end
    end
  endtask

  task automatic test_backpressure();
    int pa, pb, pc;
    logic [39:0] tx_e [3];
    tx_e = '{40'h1111_2222_21, 40'h3333_4444_43, 40'h5555_6666_65};
    do_reset();
    step(1);
    wait_phase(0);
    push(16'h1111, 16'h2222, 4'h2, 4'h1, pa);
    push(16'h3333, 16'h4444, 4'h4, 4'h3, pb);
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b want 0", bus.s_ready); end
    push(16'h5555, 16'h6666, 4'h6, 4'h5, pc);
    checks++; if (pc !== pa + 4) begin errors++; $display("FAIL bp_third_accept: got edge %0d want %0d", pc, pa + 4); end
    step(24);
    for (int i = 0; i < 3; i++) exp_q.push_back(tx_e[i]);
    checks++; if (tile_seen.size() !== 3) begin errors++; $display("FAIL bp_tx_count: got %0d want 3", tile_seen.size()); end
    checks++; if (m_seen.size() !== 3) begin errors++; $display("FAIL bp_m_count: got %0d want 3", m_seen.size()); end
    for (int i = 0; i < 3 && i < tile_seen.size(); i++) begin
      checks++; if (tile_seen[i] !== tx_e[i]) begin errors++; $display("FAIL bp_tx_frame%0d: got %h want %h", i, tile_seen[i], tx_e[i]); end
      checks++; if (tile_stamp[i] !== pa + 7 + 4*i) begin errors++; $display("FAIL bp_tx_time%0d: got edge %0d want %0d", i, tile_stamp[i], pa + 7 + 4*i); end
    end
    for (int i = 0; i < 3 && i < m_seen.size(); i++) begin
      checks++; if (m_seen[i] !== exp_q[i]) begin errors++; $display("FAIL bp_m_frame%0d: got %h want %h", i, m_seen[i], exp_q[i]); end
      checks++; if (m_stamp[i] !== pa + 11 + 4*i) begin errors++; $display("FAIL bp_m_time%0d: got edge %0d want %0d", i, m_stamp[i], pa + 11 + 4*i); end
    end
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      checks++; if ({tile_ui_in, tile_uio_in} !== 10'd0) begin errors++; $display("FAIL idle_tile_in@%0d: got %h want 0", i, {tile_ui_in, tile_uio_in}); end
      step(1);
    end
    checks++; if (m_seen.size() !== 0) begin errors++; $display("FAIL idle_m_valid: got %0d pulses want 0", m_seen.size()); end
    checks++; if (tile_seen.size() !== 0) begin errors++; $display("FAIL idle_tx_frames: got %0d want 0", tile_seen.size()); end
  endtask

  task automatic test_mid_reset();
    int pa, pb, pc;
    do_reset();
    wait_phase(1);
    push(16'h9876, 16'h5432, 4'h1, 4'h2, pa);
    push(16'h1357, 16'h2468, 4'h3, 4'h3, pb);
    step(1);
    push(16'hAAAA, 16'h5555, 4'h1, 4'h1, pc);
    checks++; if (tile_ui_in !== 8'h84) begin errors++; $display("FAIL mid_beat1: got %h want 84", tile_ui_in); end
    rst = 1'b1;
    step(1);
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL mid_phase: got %0d want 0", phase); end
    checks++; if ({tile_ui_in, tile_uio_in} !== 10'd0) begin errors++; $display("FAIL mid_tile_in: got %h want 0", {tile_ui_in, tile_uio_in}); end
    checks++; if ({bus.m_valid, bus.m_col, bus.m_row, bus.m_col_ctrl, bus.m_row_ctrl} !== 41'd0) begin
      errors++; $display("FAIL mid_m_out: got %h want 0", {bus.m_valid, bus.m_col, bus.m_row, bus.m_col_ctrl, bus.m_row_ctrl}); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL mid_s_ready_rst: got %b want 0", bus.s_ready); end
    rst = 1'b0;
    #1;
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL mid_fifo_flushed: got s_ready=%b want 1", bus.s_ready); end
    step(20);
    checks++; if (m_seen.size() !== 0) begin errors++; $display("FAIL mid_m_valid: got %0d pulses want 0", m_seen.size()); end
    checks++; if (tile_seen.size() !== 0) begin errors++; $display("FAIL mid_tx_frames: got %0d want 0", tile_seen.size()); end
  endtask

  task automatic test_boundary_push();
    int p;
    do_reset();
    wait_phase(3);
    push(16'h5A5A, 16'hC3C3, 4'h4, 4'h2, p);
    checks++; if (tile_ui_in !== 8'h00) begin errors++; $display("FAIL bnd_current_idle: got %h want 00", tile_ui_in); end
    step(20);
    checks++; if (tile_seen.size() !== 1) begin errors++; $display("FAIL bnd_tx_count: got %0d want 1", tile_seen.size()); end
    if (tile_seen.size() > 0) begin
      checks++; if (tile_stamp[0] !== p + 8) begin errors++; $display("FAIL bnd_tx_time: got edge %0d want %0d", tile_stamp[0], p + 8); end
    end
    checks++; if (m_seen.size() !== 1) begin errors++; $display("FAIL bnd_m_count: got %0d want 1", m_seen.size()); end
    if (m_seen.size() > 0) begin
      checks++; if (m_seen[0] !== 40'h5A5A_C3C3_42) begin errors++; $display("FAIL bnd_m_frame: got %h want 5a5ac3c342", m_seen[0]); end
      checks++; if (m_stamp[0] !== p + 12) begin errors++; $display("FAIL bnd_m_time: got edge %0d want %0d", m_stamp[0], p + 12); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.s_valid = 1'b0; bus.s_col = '0; bus.s_row = '0;
    bus.s_col_ctrl = '0; bus.s_row_ctrl = '0;
    test_reset();
    test_passthrough();
    test_accumulator();
    test_backpressure();
    test_idle();
    test_mid_reset();
    test_boundary_push();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_host_link.md
# systolic_host_link

Host-side link block that sits directly upstream and downstream of one systolic tile. It accepts whole 40-bit frames (two 16-bit data words plus two 4-bit control words) over a valid/ready interface and buffers them in a small FIFO. It serialises each frame into the tile's 4-beat nibble protocol, phase-locked to the tile's internal 2-bit beat counter. It also reassembles the tile's serial output back into whole frames for the host.

## Interface
- `DEPTH`, default 2: FIFO depth in frames; must be a power of two and ≥ 2.
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `s_valid` in 1: a host frame is offered.
- `s_ready` out 1: high when the FIFO is not full.
- `s_col` in 16: column data word.
- `s_row` in 16: row data word.
- `s_col_ctrl` in 4: column control word.
- `s_row_ctrl` in 4: row control word.
- `tile_ui_in` out 8: to the tile's dedicated inputs; {col nibble, row nibble}.
- `tile_uio_in` out 2: to the tile's bidirectional inputs; [1] is the column control bit, [0] is the row control bit.
- `tile_rst_n` out 1: tile reset, equal to `~rst`, combinational.
- `tile_uo_out` in 8: tile data outputs; {col nibble, row nibble}.
- `tile_uio_out` in 2: tile control outputs; [1] column, [0] row.
- `phase` out 2: beat counter; mirrors the tile's counter.
- `m_valid` out 1: single-cycle pulse carrying a reassembled frame. There is no ready; the consumer must accept it.
- `m_col` out 16, `m_row` out 16, `m_col_ctrl` out 4, `m_row_ctrl` out 4: the reassembled frame.

## Operation
- Beat counter:
  - `phase` resets to 0 and then increments and wraps every cycle.
  - Because `tile_rst_n` tracks `rst`, the tile counter resets on the same edge and stays equal to `phase`.
- TX FIFO:
  - A push happens on any edge where `s_valid && s_ready`.
  - A pop happens only on an edge where `phase==3` and the FIFO was non-empty before that edge.
  - There is no bypass. A frame pushed into an empty FIFO on a `phase==3` edge waits for the next frame boundary.
  - A push and a pop on the same edge are both honoured and the occupancy is unchanged.
- TX shift register (40 bits):
  - On each `phase==3` edge it loads the popped frame, or all-zeros if the FIFO is empty (an idle frame).
  - During phase p it drives nibble `[15-4p:12-4p]` of col and row on `tile_ui_in`, and bit `[3-p]` of each control word on `tile_uio_in`.
  - The beat order is MSB-first, and p=0 carries bits 15:12.
  - An all-zero frame is a no-op for the tile: it does not save, load or read.
- RX:
  - On every edge, the RX shift register captures `tile_uo_out` and `tile_uio_out` into the slot for the current phase.
  - On a `phase==3` edge it registers the complete frame onto the `m_*` outputs.
  - `m_valid` is set only if `m_col_ctrl|m_row_ctrl` is nonzero; frames with all-zero control are dropped.
- Reset, including mid-frame:
  - The FIFO is flushed and both shift registers are zeroed.
  - `phase` returns to 0, `m_valid` goes to 0, and all `m_*` outputs go to 0.
  - Partial frames are discarded.
- Output reset values: `s_ready` 0 while `rst` is high; `tile_ui_in` 0, `tile_uio_in` 0, `m_*` 0, `phase` 0.

## Timing
- Let E be the edge that loads a frame.
- TX beats occupy the 4 cycles after E (phases 0–3).
- The tile echoes the frame one frame later.
- `m_valid` is high during the phase-0 cycle that starts 8 edges after E.
- Throughput is one frame per 4 cycles.
- The first frame after reset is always idle on both TX and RX.
- Minimum push-to-transmit latency is 1 cycle; the maximum is 4 cycles plus the wait while earlier queued frames are sent.

## Structure
- Package `systolic_link_pkg`:
  - `frame_t` struct: col[15:0], row[15:0], col_ctrl[3:0], row_ctrl[3:0].
  - Constants `BEATS=4` and `PHASE_LAST=2'd3`.
  - Function `nibble_sel(frame_t, phase)`.
- Sub-module `link_fifo`: a synchronous FIFO of `frame_t`, DEPTH entries, with full and empty flags.
- TX serialiser, RX deserialiser and the phase counter sit in the top module.

## Test plan
- Passthrough:
  - Stimulus: push col=16'h1234, row=16'hABCD, ctrls=4'b0001.
  - TX beats: `tile_ui_in` shows 8'h1A, 8'h2B, 8'h3C, 8'h4D with `tile_uio_in` 00, 00, 00, 11.
  - RX: `m_valid` rises 8 cycles after load with identical fields.
- Accumulator load then read:
  - Frame 1: col=16'h0102, row=16'h0304, col_ctrl=4'b1000, row_ctrl=4'b0100.
  - Frame 2: same control, data 16'hFFFF.
  - Frame 2's echo must return m_col=16'h0102 and m_row=16'h0304.
- Backpressure:
  - Stimulus: DEPTH=2, push 3 frames on consecutive cycles starting right after a phase-3 edge.
  - Required: `s_ready` drops after the 2nd push and rises after the next phase-3 pop.
  - All 3 frames exit in order, 4 cycles apart.
- Idle:
  - Stimulus: no pushes for 40 cycles after reset.
  - Required: `tile_ui_in`=0 and `tile_uio_in`=0 throughout; `m_valid` never asserts.
- Mid-frame reset:
  - Stimulus: assert `rst` at phase 1 of a transmitting frame.
  - Required: the next cycle shows `phase`=0, all outputs 0 and an empty FIFO; no `m_valid` for that frame after release.
- Boundary push:
  - Stimulus: push into an empty FIFO on a phase-3 edge.
  - Required: the frame transmits in the following frame, not the current boundary.
